imem_loader: RTL and testbench

- Writer side of the instruction-memory interface. Receives a program as a byte stream over a valid/ready handshake and packs the bytes into N-bit little-endian instruction words.
- Writes each word into a writable instruction RAM at consecutive word addresses starting at 0.
- Holds the processor via cpu_hold while a load is in progress.
- Sits between a host/UART byte source and the RAM port that backs the processor's instruction fetch.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_byte_packer.sv | 43 ++++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader and any
// future memory loaders built on the same byte packer.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    localparam int IMEM_N         = 32;
    localparam int BYTES_PER_WORD = IMEM_N / 8;
    localparam int IMEM_ADDR_W    = 7;
    localparam int IMEM_DEPTH     = 128;

    // A one-byte word still needs a 1-bit index to stay a legal vector.
    function automatic int idx_width(input int bytes_per_word);
        return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: the first byte loaded lands in bits [7:0].
// full flags that the byte being loaded now completes the word.
module byte_packer
    import imem_loader_pkg::*;
#(
    parameter int N = IMEM_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clear,
    input  logic         load,
    input  logic [7:0]   byte_in,
    output logic [N-1:0] word_next,
    output logic         full
);

    localparam int BPW   = N / 8;
    localparam int IDX_W = idx_width(BPW);

    logic [IDX_W-1:0] idx;
    logic [N-1:0]     shift;

    always_comb begin
        word_next = shift;
        word_next[{idx, 3'b000} +: 8] = byte_in;
    end

    assign full = (idx == IDX_W'(BPW - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx   <= '0;
            shift <= '0;
        end else if (clear) begin
            idx   <= '0;
            shift <= '0;
        end else if (load) begin
            shift <= word_next;
            idx   <= full ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into the instruction RAM as packed words and holds
// the processor off while the load is in flight.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   RECV  | accepting bytes of the current word
//   WRITE | one-cycle RAM write of the assembled word
//   DONE  | load finished (or rejected); done/err held until next start
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N      = IMEM_N,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx_plus;
    logic              err_q;
    logic              start_ok, count_zero, count_over, begin_load;
    logic              accept, word_full;
    logic [N-1:0]      word_next;

    assign start_ok   = start && (state == IDLE || state == DONE);
    assign count_zero = (word_count == '0);
    assign count_over = (word_count > DEPTH_CNT);
    assign begin_load = start_ok && !count_zero && !count_over;
    assign accept     = byte_valid && byte_ready;
    assign idx_plus   = {1'b0, word_idx} + {{ADDR_W{1'b0}}, 1'b1};

    byte_packer #(.N(N)) u_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (begin_load),
        .load      (accept),
        .byte_in   (byte_data),
        .word_next (word_next),
        .full      (word_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start_ok) begin
                    state_next = begin_load ? RECV : DONE;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (accept && word_full) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                cpu_hold   = 1'b1;
                state_next = (idx_plus == count_q) ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write port is registered at the last byte so the strobe lands in the
    // WRITE cycle and address/data hold afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= accept && word_full;
            if (accept && word_full) begin
                wr_addr <= word_idx;
                wr_data <= word_next;
            end
            if (start_ok) begin
                err_q <= count_over;
            end
            if (begin_load) begin
                count_q  <= word_count;
                word_idx <= '0;
            end else if (state == WRITE) begin
                word_idx <= idx_plus[ADDR_W-1:0];
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-packed expected words.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int passed = 0;
    int wn = 0;
    int acc = 0;
    int ready_in_wr = 0;
    logic [6:0]  la [64];
    logic [31:0] ld [64];

    imem_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            la[wn[5:0]] <= wr_addr;
            ld[wn[5:0]] <= wr_data;
            wn <= wn + 1;
        end
        if (byte_valid && byte_ready) acc <= acc + 1;
        if (wr_en && byte_ready) ready_in_wr <= ready_in_wr + 1;
    end

    function automatic logic [5:0] ix(input int i);
        return i[5:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] wc);
        start = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data = b;
        @(negedge clk);
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("byte_timeout", 1, 0);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int stall);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            for (int k = 0; k < stall; k++) tick();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("done_timeout", 1, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, base2, acc0, viol0;
        reset_n = 1'b0;
        start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        @(negedge clk);
        chk("reset_outputs", {byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err}, 44'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // single word
        base = wn;
        do_start(8'd1);
        chk("t1_hold", cpu_hold, 1);
        chk("t1_ready", byte_ready, 1);
        chk("t1_done_low", done, 0);
        send_word(32'h8b050083, 0);
        wait_done();
        chk("t1_nwrites", wn - base, 1);
        chk("t1_addr", la[ix(base)], 7'd0);
        chk("t1_data", ld[ix(base)], 32'h8b050083);
        chk("t1_done", done, 1);
        chk("t1_hold_low", cpu_hold, 0);
        chk("t1_err", err, 0);

        // two words with a stalling source
        base = wn;
        acc0 = acc;
        viol0 = ready_in_wr;
        do_start(8'd2);
        send_word(32'h8b050083, 3);
        send_word(32'hf8018003, 3);
        wait_done();
        chk("t2_nwrites", wn - base, 2);
        chk("t2_addr0", la[ix(base)], 7'd0);
        chk("t2_data0", ld[ix(base)], 32'h8b050083);
        chk("t2_addr1", la[ix(base + 1)], 7'd1);
        chk("t2_data1", ld[ix(base + 1)], 32'hf8018003);
        chk("t2_accepted", acc - acc0, 8);
        chk("t2_ready_in_write", ready_in_wr - viol0, 0);

        // illegal counts
        base = wn;
        do_start(8'd0);
        chk("t3_zero_done", done, 1);
        chk("t3_zero_err", err, 0);
        chk("t3_zero_hold", cpu_hold, 0);
        do_start(8'd129);
        chk("t3_over_done", done, 1);
        chk("t3_over_err", err, 1);
        tick();
        tick();
        chk("t3_no_writes", wn - base, 0);

        // reset in the middle of a load
        base = wn;
        do_start(8'd3);
        send_word(32'h44332211, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        reset_n = 1'b0;
        #1;
        chk("t4_reset_outputs", {byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err}, 44'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("t4_nwrites_pre", wn - base, 1);
        chk("t4_addr_pre", la[ix(base)], 7'd0);
        chk("t4_data_pre", ld[ix(base)], 32'h44332211);
        base2 = wn;
        do_start(8'd1);
        send_word(32'h80031fd6, 0);
        wait_done();
        chk("t4_nwrites_new", wn - base2, 1);
        chk("t4_addr_new", la[ix(base2)], 7'd0);
        chk("t4_data_new", ld[ix(base2)], 32'h80031fd6);

        // start while busy is ignored; start in DONE reloads from address 0
        base = wn;
        acc0 = acc;
        viol0 = ready_in_wr;
        do_start(8'd2);
        send_byte(8'h83);
        send_byte(8'h00);
        start = 1'b1;
        word_count = 8'd1;
        send_byte(8'h05);
        start = 1'b0;
        send_byte(8'h8b);
        send_word(32'hf8018003, 0);
        wait_done();
        chk("t5_nwrites", wn - base, 2);
        chk("t5_addr0", la[ix(base)], 7'd0);
        chk("t5_data0", ld[ix(base)], 32'h8b050083);
        chk("t5_addr1", la[ix(base + 1)], 7'd1);
        chk("t5_data1", ld[ix(base + 1)], 32'hf8018003);
        chk("t5_accepted", acc - acc0, 8);
        chk("t5_ready_in_write", ready_in_wr - viol0, 0);
        do_start(8'd1);
        chk("t5_done_cleared", done, 0);
        chk("t5_hold_again", cpu_hold, 1);
        send_word(32'h00c0ffee, 0);
        wait_done();
        chk("t5_reload_nwrites", wn - base, 3);
        chk("t5_reload_addr", la[ix(base + 2)], 7'd0);
        chk("t5_reload_data", ld[ix(base + 2)], 32'h00c0ffee);
        chk("t5_reload_done", done, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
